iir_coef_ctrl: RTL and testbench
================================

Name: iir_coef_ctrl

Overview:
Coefficient configuration controller for the programmable IIR filter core. It accepts coefficient writes through a valid/ready handshake into a shadow bank, then commits the whole set atomically on a sample boundary. At commit it copies the shadow bank to the active bank that drives the filter's b0..b20 / a1..a14 / order ports, and issues a one-cycle filter-state clear. The filter therefore never processes a sample with a half-updated coefficient set.

Parameters:
COEF_W, 16, coefficient width (signed fixed point, passed through unchanged)
NUM_SEC, 7, maximum second-order sections; 3*NUM_SEC b coefficients, 2*NUM_SEC a coefficients
ADDR_W, 6, coefficient address width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
wr_valid  in  1  coefficient write request
wr_ready  out  1  controller can accept a write
wr_addr  in  ADDR_W  0..20 select b0..b20; 21..34 select a1..a14
wr_data  in  COEF_W  coefficient value
commit  in  1  request to apply shadow bank (level sampled in IDLE)
order_in  in  4  number of sections for the next commit, valid 1..NUM_SEC
sample_stb  in  1  one-cycle pulse, filter sample boundary
b_coef  out  3*NUM_SEC*COEF_W  active b coefficients, b0 in the LSBs
a_coef  out  2*NUM_SEC*COEF_W  active a coefficients, a1 in the LSBs
order  out  4  active section count
filt_clr  out  1  one-cycle pulse to clear the filter delay lines
commit_done  out  1  one-cycle pulse when the new set is active
err  out  1  one-cycle pulse on a bad address or bad order
busy  out  1  high in PEND and SWAP

Behaviour:
- Reset (reset=0): state IDLE; shadow and active banks all zero; order=1; wr_ready=1; filt_clr, commit_done, err, busy = 0; any pending commit is dropped. Reset mid-PEND returns to IDLE with no swap.
- All outputs are registered.
- Write handshake: a transfer occurs when wr_valid && wr_ready on a clk edge. Shadow[wr_addr] is updated at that edge. wr_ready=1 only in IDLE.
- Address 35..63: no shadow write; err pulses the next cycle; the transfer still completes.
- FSM:
  - IDLE: on commit, check order_in. If order_in is 0 or >NUM_SEC, pulse err and stay in IDLE. Otherwise latch order_in, go to PEND, and drop wr_ready next cycle.
  - PEND: wait for sample_stb. If sample_stb is high, go to SWAP. commit is ignored in PEND.
  - SWAP (one cycle): active<=shadow; order<=latched order; filt_clr=1; commit_done=1; next state IDLE.
- Latency: from sample_stb in PEND, new b_coef/a_coef/order are visible 2 edges later (PEND->SWAP, SWAP register update). filt_clr and commit_done are asserted in the same cycle the new coefficients appear.
- Simultaneous write and commit in IDLE: the write is applied first, and the committed set includes it.
- sample_stb in IDLE or SWAP has no effect. sample_stb held high continuously in PEND gives a single swap.
- The shadow bank retains its contents after a commit, so incremental updates only need the changed words.
- No arithmetic on coefficient values; bit-exact pass-through.

Optional Feature:
COEF_MASK_EN
- Defined: during SWAP, active b coefficients with index >= 3*order and active a coefficients with index >= 2*order are loaded as zero. Shadow contents are unchanged.
- Undefined: all shadow words are copied verbatim, regardless of order.

Test Plan:
- Reset: assert reset=0 mid-PEND -> order=1, buses all zero, wr_ready=1, busy=0, no filt_clr.
- Write b0=0x0005, b1=0x0008, b2=0x0005, a1=0xF8E2, a2=0x07EB; commit with order_in=1; pulse sample_stb -> 2 edges later b_coef[47:0]=0x0005_0008_0005, a_coef[31:0]=0x07EB_F8E2, order=1, filt_clr and commit_done pulse for exactly 1 cycle.
- Write to addr 40 with data 0x1234 -> err pulses once, shadow unchanged; a later commit shows no 0x1234 on any bus.
- Commit with order_in=0, then with order_in=8 -> err pulses each time, state stays IDLE, active bank and order unchanged.
- Same-cycle write addr 3 = 0x0800 and commit with order_in=2; hold sample_stb low for 10 cycles -> wr_ready=0 and busy=1 throughout, active unchanged. Pulse sample_stb -> b3=0x0800 active, order=2.
- With COEF_MASK_EN: shadow b6=0x0100 and a5=0x0200, commit order_in=2 -> active b6=0 and a5=0. Without the macro -> b6=0x0100 and a5=0x0200.

Source files
------------

// File: rtl/iir_coef_ctrl.sv
// Coefficient bank controller for the IIR filter core: shadow writes via valid/ready,
// atomic shadow->active swap on a sample boundary. Optional COEF_MASK_EN zeroes unused sections at swap.
module iir_coef_ctrl #(
    parameter int COEF_W  = 16,
    parameter int NUM_SEC = 7,
    parameter int ADDR_W  = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [COEF_W-1:0]             wr_data,
    input  logic                          commit,
    input  logic [3:0]                    order_in,
    input  logic                          sample_stb,
    output logic [3*NUM_SEC*COEF_W-1:0]   b_coef,
    output logic [2*NUM_SEC*COEF_W-1:0]   a_coef,
    output logic [3:0]                    order,
    output logic                          filt_clr,
    output logic                          commit_done,
    output logic                          err,
    output logic                          busy
);

    localparam int NB = 3 * NUM_SEC;
    localparam int NA = 2 * NUM_SEC;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        SWAP
    } state_t;

    state_t state, next_state;

    logic [NB*COEF_W-1:0] shadow_b;
    logic [NA*COEF_W-1:0] shadow_a;
    logic [NB*COEF_W-1:0] swap_b;
    logic [NA*COEF_W-1:0] swap_a;
    logic [3:0]           order_lat;

    logic wr_en;
    logic addr_bad;
    logic order_ok;
    logic commit_ok;
    logic commit_bad;

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        wr_en      = wr_valid && wr_ready;
        addr_bad   = wr_en && (int'(wr_addr) >= NB + NA);
        order_ok   = (order_in != 4'd0) && (order_in <= 4'(NUM_SEC));
        commit_ok  = (state == IDLE) && commit && order_ok;
        commit_bad = (state == IDLE) && commit && !order_ok;

        unique case (state)
            IDLE: if (commit_ok)  next_state = PEND;
            PEND: if (sample_stb) next_state = SWAP;
            SWAP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Shadow bank; a write in the same cycle as a commit lands before the swap reads it.
    // NOTE: the banks are plain flops, so they are reset like any other register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_b <= '0;
            shadow_a <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_addr == ADDR_W'(i)) shadow_b[i*COEF_W +: COEF_W] <= wr_data;
            end
            for (int i = 0; i < NA; i++) begin
                if (wr_addr == ADDR_W'(NB + i)) shadow_a[i*COEF_W +: COEF_W] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         order_lat <= 4'd1;
        else if (commit_ok) order_lat <= order_in;
    end

    // Data presented to the active bank at swap time.
    always_comb begin
        swap_b = shadow_b;
        swap_a = shadow_a;
`ifdef COEF_MASK_EN
        for (int i = 0; i < NB; i++) begin
            if (i >= 3 * int'(order_lat)) swap_b[i*COEF_W +: COEF_W] = '0;
        end
        for (int i = 0; i < NA; i++) begin
            if (i >= 2 * int'(order_lat)) swap_a[i*COEF_W +: COEF_W] = '0;
        end
`endif
    end

    // Registered outputs; handshake/status follow the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ready    <= 1'b1;
            busy        <= 1'b0;
            err         <= 1'b0;
            filt_clr    <= 1'b0;
            commit_done <= 1'b0;
            b_coef      <= '0;
            a_coef      <= '0;
            order       <= 4'd1;
        end else begin
            wr_ready    <= (next_state == IDLE);
            busy        <= (next_state != IDLE);
            err         <= addr_bad || commit_bad;
            filt_clr    <= (state == SWAP);
            commit_done <= (state == SWAP);
            if (state == SWAP) begin
                b_coef <= swap_b;
                a_coef <= swap_a;
                order  <= order_lat;
            end
        end
    end

endmodule

// File: tb/tb_iir_coef_ctrl.sv
// Directed bench for iir_coef_ctrl: write/commit/swap sequencing, error pulses, reset mid-commit.
module tb_iir_coef_ctrl;

    localparam int COEF_W  = 16;
    localparam int NUM_SEC = 7;
    localparam int ADDR_W  = 6;
    localparam int BW      = 3 * NUM_SEC * COEF_W;
    localparam int AW      = 2 * NUM_SEC * COEF_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [COEF_W-1:0] wr_data;
    logic              commit;
    logic [3:0]        order_in;
    logic              sample_stb;
    logic [BW-1:0]     b_coef;
    logic [AW-1:0]     a_coef;
    logic [3:0]        order;
    logic              filt_clr;
    logic              commit_done;
    logic              err;
    logic              busy;

    logic [BW-1:0]     exp_b;
    logic [AW-1:0]     exp_a;
    int                n_cmp = 0;
    int                n_err = 0;

    iir_coef_ctrl #(.COEF_W(COEF_W), .NUM_SEC(NUM_SEC), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .order_in(order_in), .sample_stb(sample_stb),
        .b_coef(b_coef), .a_coef(a_coef), .order(order),
        .filt_clr(filt_clr), .commit_done(commit_done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [COEF_W-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_commit(input logic [3:0] o);
        commit   = 1'b1;
        order_in = o;
        tick();
        commit   = 1'b0;
    endtask

    // One-cycle sample pulse, then wait for the swap edge.
    task automatic swap();
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        commit = 1'b0; order_in = 4'd0; sample_stb = 1'b0;
        exp_b = '0; exp_a = '0;
        repeat (3) tick();

        check("rst_b", BW'(b_coef), BW'(exp_b));
        check("rst_a", BW'(a_coef), BW'(exp_a));
        check("rst_order", BW'(order), BW'(4'd1));
        check("rst_ready", BW'(wr_ready), BW'(1'b1));
        check("rst_busy", BW'(busy), BW'(1'b0));
        check("rst_clr", BW'(filt_clr), BW'(1'b0));
        check("rst_done", BW'(commit_done), BW'(1'b0));
        check("rst_err", BW'(err), BW'(1'b0));
        reset = 1'b1;
        tick();

        // Basic first-order set
        wr(6'd0, 16'h0005);
        wr(6'd1, 16'h0008);
        wr(6'd2, 16'h0005);
        wr(6'd21, 16'hF8E2);
        wr(6'd22, 16'h07EB);
        check("wr_err", BW'(err), BW'(1'b0));
        do_commit(4'd1);
        check("pend_busy", BW'(busy), BW'(1'b1));
        check("pend_ready", BW'(wr_ready), BW'(1'b0));
        check("pend_b", BW'(b_coef), BW'(exp_b));
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        check("swap_clr", BW'(filt_clr), BW'(1'b0));
        check("swap_b", BW'(b_coef), BW'(exp_b));
        tick();
        exp_b[47:0] = 48'h0005_0008_0005;
        exp_a[31:0] = 32'h07EB_F8E2;
        check("c1_b", BW'(b_coef), BW'(exp_b));
        check("c1_a", BW'(a_coef), BW'(exp_a));
        check("c1_order", BW'(order), BW'(4'd1));
        check("c1_clr", BW'(filt_clr), BW'(1'b1));
        check("c1_done", BW'(commit_done), BW'(1'b1));
        check("c1_busy", BW'(busy), BW'(1'b0));
        check("c1_ready", BW'(wr_ready), BW'(1'b1));
        tick();
        check("c1_clr_end", BW'(filt_clr), BW'(1'b0));
        check("c1_done_end", BW'(commit_done), BW'(1'b0));

        // Out-of-range address
        wr(6'd40, 16'h1234);
        check("addr_err", BW'(err), BW'(1'b1));
        tick();
        check("addr_err_end", BW'(err), BW'(1'b0));
        do_commit(4'd1);
        swap();
        check("addr_b", BW'(b_coef), BW'(exp_b));
        check("addr_a", BW'(a_coef), BW'(exp_a));
        check("addr_done", BW'(commit_done), BW'(1'b1));
        tick();

        // Bad orders
        do_commit(4'd0);
        check("ord0_err", BW'(err), BW'(1'b1));
        check("ord0_busy", BW'(busy), BW'(1'b0));
        check("ord0_ready", BW'(wr_ready), BW'(1'b1));
        tick();
        check("ord0_err_end", BW'(err), BW'(1'b0));
        do_commit(4'd8);
        check("ord8_err", BW'(err), BW'(1'b1));
        check("ord8_busy", BW'(busy), BW'(1'b0));
        tick();
        check("ord8_err_end", BW'(err), BW'(1'b0));
        swap();
        check("bad_noclr", BW'(filt_clr), BW'(1'b0));
        check("bad_nodone", BW'(commit_done), BW'(1'b0));
        check("bad_order", BW'(order), BW'(4'd1));
        check("bad_b", BW'(b_coef), BW'(exp_b));

        // Same-cycle write and commit, long wait in PEND with commit held (ignored)
        wr_valid = 1'b1; wr_addr = 6'd3; wr_data = 16'h0800;
        commit = 1'b1; order_in = 4'd2;
        tick();
        wr_valid = 1'b0;
        order_in = 4'd0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("wait_ready", BW'(wr_ready), BW'(1'b0));
            check("wait_busy", BW'(busy), BW'(1'b1));
            check("wait_err", BW'(err), BW'(1'b0));
            check("wait_b", BW'(b_coef), BW'(exp_b));
        end
        commit = 1'b0;
        sample_stb = 1'b1;
        tick();
        tick();
        exp_b[63:48] = 16'h0800;
        check("c2_b", BW'(b_coef), BW'(exp_b));
        check("c2_order", BW'(order), BW'(4'd2));
        check("c2_done", BW'(commit_done), BW'(1'b1));
        tick();
        check("stb_hold_done", BW'(commit_done), BW'(1'b0));
        check("stb_hold_busy", BW'(busy), BW'(1'b0));
        tick();
        check("stb_hold_done2", BW'(commit_done), BW'(1'b0));
        sample_stb = 1'b0;

        // Words beyond the active order
        wr(6'd6, 16'h0100);
        wr(6'd25, 16'h0200);
        do_commit(4'd2);
        swap();
`ifndef COEF_MASK_EN
        exp_b[111:96] = 16'h0100;
        exp_a[79:64]  = 16'h0200;
`endif
        check("mask_b", BW'(b_coef), BW'(exp_b));
        check("mask_a", BW'(a_coef), BW'(exp_a));
        check("mask_order", BW'(order), BW'(4'd2));
        tick();

        // Reset while a commit is pending
        do_commit(4'd3);
        check("pre_rst_busy", BW'(busy), BW'(1'b1));
        reset = 1'b0;
        #2;
        exp_b = '0;
        exp_a = '0;
        check("mrst_b", BW'(b_coef), BW'(exp_b));
        check("mrst_a", BW'(a_coef), BW'(exp_a));
        check("mrst_order", BW'(order), BW'(4'd1));
        check("mrst_ready", BW'(wr_ready), BW'(1'b1));
        check("mrst_busy", BW'(busy), BW'(1'b0));
        check("mrst_clr", BW'(filt_clr), BW'(1'b0));
        reset = 1'b1;
        tick();
        swap();
        check("drop_clr", BW'(filt_clr), BW'(1'b0));
        check("drop_done", BW'(commit_done), BW'(1'b0));
        check("drop_order", BW'(order), BW'(4'd1));
        do_commit(4'd1);
        swap();
        check("shadow_clr_b", BW'(b_coef), BW'(exp_b));
        check("shadow_clr_a", BW'(a_coef), BW'(exp_a));
        check("shadow_clr_done", BW'(commit_done), BW'(1'b1));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
